// File: rtl/md_unit_if.sv
`default_nettype none
// ============================================================================
// md_unit_if : command/result bundle between the E-stage decoder and md_unit.
// Build option: MDU_CANCEL_EN adds the cancel line.  Revision: 1.0
// ============================================================================
interface md_unit_if;
  logic [3:0]  MDType;
  logic        start;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
`ifdef MDU_CANCEL_EN
  logic        cancel;
`endif
  logic        busy;
  logic [31:0] md_out;
  logic [31:0] hi;
  logic [31:0] lo;

`ifdef MDU_CANCEL_EN
  modport master (output MDType, start, rs_data, rt_data, cancel,
                  input  busy, md_out, hi, lo);
  modport slave  (input  MDType, start, rs_data, rt_data, cancel,
                  output busy, md_out, hi, lo);
`else
  modport master (output MDType, start, rs_data, rt_data,
                  input  busy, md_out, hi, lo);
  modport slave  (input  MDType, start, rs_data, rt_data,
                  output busy, md_out, hi, lo);
`endif
endinterface
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// md_unit : multi-cycle multiply/divide unit owning HI/LO (mult/multu/msub/
// div/divu, mfhi/mflo/mthi/mtlo). Build option: MDU_CANCEL_EN. Revision: 1.0
// ============================================================================
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  wire logic clk,
  input  wire logic reset_n,
  md_unit_if.slave  bus
);
  localparam int C_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int C_CW  = $clog2(C_MAX + 1);

  localparam logic [3:0] C_OP_DIV   = 4'b0001;
  localparam logic [3:0] C_OP_DIVU  = 4'b0010;
  localparam logic [3:0] C_OP_MULT  = 4'b0011;
  localparam logic [3:0] C_OP_MULTU = 4'b0100;
  localparam logic [3:0] C_OP_MFHI  = 4'b0101;
  localparam logic [3:0] C_OP_MFLO  = 4'b0110;
  localparam logic [3:0] C_OP_MTHI  = 4'b0111;
  localparam logic [3:0] C_OP_MTLO  = 4'b1000;
  localparam logic [3:0] C_OP_MSUB  = 4'b1001;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t          r_state, w_state_nxt;
  logic [C_CW-1:0] r_count, w_count_nxt;
  logic [3:0]      r_op,    w_op_nxt;
  logic [31:0]     r_a,     w_a_nxt;
  logic [31:0]     r_b,     w_b_nxt;
  logic [31:0]     r_hi,    w_hi_nxt;
  logic [31:0]     r_lo,    w_lo_nxt;
  logic            w_cancel;

`ifdef MDU_CANCEL_EN
  assign w_cancel = bus.cancel;
`else
  assign w_cancel = 1'b0;
`endif

  // Result datapath works on the latched operands; HI/LO cannot move while RUN.
  logic [63:0] w_prod_s, w_prod_u, w_msub;
  logic [31:0] w_abs_a, w_abs_b, w_uq, w_ur, w_sq, w_sr, w_q_u, w_r_u;
  logic        w_div_zero;

  assign w_prod_s   = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
  assign w_prod_u   = {32'd0, r_a} * {32'd0, r_b};
  assign w_msub     = {r_hi, r_lo} - w_prod_s;
  // Magnitude division keeps 0x80000000 / -1 well defined (wraps to 0x80000000).
  assign w_abs_a    = r_a[31] ? (32'd0 - r_a) : r_a;
  assign w_abs_b    = r_b[31] ? (32'd0 - r_b) : r_b;
  assign w_uq       = w_abs_a / w_abs_b;
  assign w_ur       = w_abs_a % w_abs_b;
  assign w_sq       = (r_a[31] ^ r_b[31]) ? (32'd0 - w_uq) : w_uq;
  assign w_sr       = r_a[31] ? (32'd0 - w_ur) : w_ur;
  assign w_q_u      = r_a / r_b;
  assign w_r_u      = r_a % r_b;
  assign w_div_zero = (r_b == 32'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_op    <= 4'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_op    <= w_op_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_op_nxt    = r_op;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    case (r_state)
      S_IDLE: begin
        if (bus.start && !w_cancel) begin
          case (bus.MDType)
            C_OP_MULT, C_OP_MULTU, C_OP_MSUB: begin
              w_op_nxt    = bus.MDType;
              w_a_nxt     = bus.rs_data;
              w_b_nxt     = bus.rt_data;
              w_count_nxt = C_CW'(MULT_CYCLES);
              w_state_nxt = S_RUN;
            end
            C_OP_DIV, C_OP_DIVU: begin
              w_op_nxt    = bus.MDType;
              w_a_nxt     = bus.rs_data;
              w_b_nxt     = bus.rt_data;
              w_count_nxt = C_CW'(DIV_CYCLES);
              w_state_nxt = S_RUN;
            end
            C_OP_MTHI: w_hi_nxt = bus.rs_data;
            C_OP_MTLO: w_lo_nxt = bus.rs_data;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (w_cancel) begin
          w_state_nxt = S_IDLE;
          w_count_nxt = '0;
        end else if (r_count == C_CW'(1)) begin
          w_state_nxt = S_IDLE;
          w_count_nxt = '0;
          case (r_op)
            C_OP_MULT:  {w_hi_nxt, w_lo_nxt} = w_prod_s;
            C_OP_MULTU: {w_hi_nxt, w_lo_nxt} = w_prod_u;
            C_OP_MSUB:  {w_hi_nxt, w_lo_nxt} = w_msub;
            C_OP_DIV: begin
              if (!w_div_zero) begin
                w_hi_nxt = w_sr;
                w_lo_nxt = w_sq;
              end
            end
            C_OP_DIVU: begin
              if (!w_div_zero) begin
                w_hi_nxt = w_r_u;
                w_lo_nxt = w_q_u;
              end
            end
            default: ;
          endcase
        end else begin
          w_count_nxt = r_count - C_CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.md_out = 32'd0;
    if (bus.MDType == C_OP_MFHI)      bus.md_out = r_hi;
    else if (bus.MDType == C_OP_MFLO) bus.md_out = r_lo;
  end

  assign bus.busy = (r_state == S_RUN);
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// tb_md_unit : table-driven, scoreboarded bench for md_unit.
// Build option: MDU_CANCEL_EN enables the cancel sequences. Revision: 1.0
// ============================================================================
module tb_md_unit;
  localparam logic [3:0] OP_NONE  = 4'b0000;
  localparam logic [3:0] OP_DIV   = 4'b0001;
  localparam logic [3:0] OP_DIVU  = 4'b0010;
  localparam logic [3:0] OP_MULT  = 4'b0011;
  localparam logic [3:0] OP_MULTU = 4'b0100;
  localparam logic [3:0] OP_MFHI  = 4'b0101;
  localparam logic [3:0] OP_MFLO  = 4'b0110;
  localparam logic [3:0] OP_MTHI  = 4'b0111;
  localparam logic [3:0] OP_MTLO  = 4'b1000;
  localparam logic [3:0] OP_MSUB  = 4'b1001;
  localparam logic [3:0] OP_RSVD  = 4'b1010;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[16];
  exp_t sb[$];

  md_unit_if bus ();

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt, input logic st);
    bus.MDType  = op;
    bus.rs_data = rs;
    bus.rt_data = rt;
    bus.start   = st;
  endtask

  // Issue one command, then count the cycles busy stays high (bounded).
  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt, output int cyc);
    @(negedge clk);
    drive(op, rs, rt, 1'b1);
    @(posedge clk); #1;
    drive(OP_NONE, 32'd0, 32'd0, 1'b0);
    cyc = 0;
    while (bus.busy && cyc < 200) begin
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic read_md(input logic [3:0] op, output logic [31:0] val);
    @(negedge clk);
    drive(op, 32'd0, 32'd0, 1'b1);
    #1 val = bus.md_out;
    drive(OP_NONE, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    int          cyc;
    logic [31:0] val;
    exp_t        e;

    vecs[0]  = '{OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1]  = '{OP_MULTU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{OP_DIVU,  32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[4]  = '{OP_DIVU,  32'd7,        32'd2,        32'h00000001, 32'h00000003, 10};
    vecs[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[6]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[7]  = '{OP_MTHI,  32'd1,        32'd0,        32'h00000001, 32'hFFFFFFFD, 0};
    vecs[8]  = '{OP_MTLO,  32'd0,        32'd0,        32'h00000001, 32'h00000000, 0};
    vecs[9]  = '{OP_MSUB,  32'd1,        32'd1,        32'h00000000, 32'hFFFFFFFF, 5};
    vecs[10] = '{OP_MULT,  32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 5};
    vecs[11] = '{OP_MSUB,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFB, 5};
    vecs[12] = '{OP_NONE,  32'h0000DEAD, 32'd1,        32'hFFFFFFFF, 32'hFFFFFFFB, 0};
    vecs[13] = '{OP_RSVD,  32'h0000BEEF, 32'd1,        32'hFFFFFFFF, 32'hFFFFFFFB, 0};
    vecs[14] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[15] = '{OP_MSUB,  32'h80000000, 32'h80000000, 32'hBFFFFFFE, 32'h00000001, 5};

    drive(OP_NONE, 32'd0, 32'd0, 1'b0);
`ifdef MDU_CANCEL_EN
    bus.cancel = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    #1;
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_hi", bus.hi, 32'd0);
    check("reset_lo", bus.lo, 32'd0);

    // Asynchronous reset with three cycles left in a multiply.
    @(negedge clk);
    drive(OP_MULT, 32'h12345678, 32'd9, 1'b1);
    @(posedge clk); #1;
    drive(OP_NONE, 32'd0, 32'd0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    check("midrun_busy_before_reset", {31'd0, bus.busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrun_reset_busy", {31'd0, bus.busy}, 32'd0);
    check("midrun_reset_hi", bus.hi, 32'd0);
    check("midrun_reset_lo", bus.lo, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("post_reset_busy", {31'd0, bus.busy}, 32'd0);
    check("post_reset_hi", bus.hi, 32'd0);
    check("post_reset_lo", bus.lo, 32'd0);

    for (int i = 0; i < 16; i++) begin
      sb.push_back('{vecs[i].hi, vecs[i].lo, vecs[i].cycles});
      issue(vecs[i].op, vecs[i].rs, vecs[i].rt, cyc);
      e = sb.pop_front();
      check($sformatf("vec%0d_busy_cycles", i), 32'(cyc), 32'(e.cycles));
      check($sformatf("vec%0d_hi", i), bus.hi, e.hi);
      check($sformatf("vec%0d_lo", i), bus.lo, e.lo);
      read_md(OP_MFHI, val);
      check($sformatf("vec%0d_mfhi", i), val, e.hi);
      read_md(OP_MFLO, val);
      check($sformatf("vec%0d_mflo", i), val, e.lo);
    end

    // Commands presented while busy must not disturb the running multiply.
    sb.push_back('{32'h00000000, 32'h0000000C, 5});
    @(negedge clk);
    drive(OP_MULT, 32'd3, 32'd4, 1'b1);
    @(posedge clk); #1;
    drive(OP_NONE, 32'd0, 32'd0, 1'b0);
    cyc = 0;
    while (bus.busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
      if (cyc == 2)      drive(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
      else if (cyc == 3) drive(OP_MTHI, 32'h00000055, 32'd0, 1'b1);
      else               drive(OP_NONE, 32'd0, 32'd0, 1'b0);
      @(posedge clk); #1;
    end
    drive(OP_NONE, 32'd0, 32'd0, 1'b0);
    e = sb.pop_front();
    check("busy_ignore_cycles", 32'(cyc), 32'(e.cycles));
    check("busy_ignore_hi", bus.hi, e.hi);
    check("busy_ignore_lo", bus.lo, e.lo);
    repeat (12) @(posedge clk);
    #1;
    check("busy_ignore_no_rerun", {31'd0, bus.busy}, 32'd0);
    check("busy_ignore_hi_late", bus.hi, e.hi);
    check("busy_ignore_lo_late", bus.lo, e.lo);

`ifdef MDU_CANCEL_EN
    @(negedge clk);
    drive(OP_DIV, 32'd100, 32'd7, 1'b1);
    @(posedge clk); #1;
    drive(OP_NONE, 32'd0, 32'd0, 1'b0);
    cyc = 0;
    while (bus.busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
      bus.cancel = (cyc == 4);
      @(posedge clk); #1;
    end
    bus.cancel = 1'b0;
    check("cancel_busy_cycles", 32'(cyc), 32'd4);
    repeat (12) @(posedge clk);
    #1;
    check("cancel_hi", bus.hi, 32'h00000000);
    check("cancel_lo", bus.lo, 32'h0000000C);

    @(negedge clk);
    drive(OP_MTHI, 32'h00000077, 32'd0, 1'b1);
    bus.cancel = 1'b1;
    @(posedge clk); #1;
    drive(OP_NONE, 32'd0, 32'd0, 1'b0);
    bus.cancel = 1'b0;
    check("cancel_blocks_mthi", bus.hi, 32'h00000000);
    check("cancel_blocks_busy", {31'd0, bus.busy}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
